eth_out_arb: RTL and testbench
==============================

Name: eth_out_arb

Overview:
Per-output-port packet arbiter for the 2x2 Ethernet switch. It shares one output port (outdata/outsop/outeop) between two source FIFOs, one fed from input port A and one from port B. Arbitration is round-robin and packet-granular: once a source is granted, it keeps the port until its eop word is forwarded. Two instances are used in the switch top, one per output port.

Parameters:
DATA_W, 32, data word width
MAX_PKT_WORDS, 64, watchdog packet length limit in words (used only with ETH_ARB_WDOG_EN)

Ports:
clk  in  1  switch clock
rstn  in  1  reset; asynchronous, active-low
srcA_empty  in  1  FIFO A empty
srcA_data  in  DATA_W  FIFO A head word (first-word-fall-through)
srcA_sop  in  1  head word is start of packet
srcA_eop  in  1  head word is end of packet
srcA_rd_en  out  1  pop FIFO A head
srcB_empty, srcB_data, srcB_sop, srcB_eop, srcB_rd_en  as A, for FIFO B
out_stall  in  1  downstream cannot accept a word next cycle
outdata  out  DATA_W  forwarded word (registered)
outsop  out  1  forwarded word is sop
outeop  out  1  forwarded word is eop
outvalid  out  1  outdata/outsop/outeop valid this cycle
grant_a  out  1  state is GRANT_A
grant_b  out  1  state is GRANT_B
err_frame  out  1  one-cycle pulse: non-sop head word discarded in IDLE
err_len  out  1  one-cycle pulse: watchdog truncation (0 without macro)

Behaviour:
- Reset (async, rstn=0): state IDLE; all outputs 0; rr_last=B, so A wins the first tie.
- FIFOs are first-word-fall-through: head word is valid while !empty. rd_en pops the head on that clock edge. The arbiter never asserts rd_en to an empty FIFO.
- States: IDLE, GRANT_A, GRANT_B, plus FLUSH_A and FLUSH_B (macro only).
- IDLE:
  - Candidate x = !srcX_empty && srcX_sop.
  - Both are candidates: grant the one not equal to rr_last. One is a candidate: grant it.
  - Next state is GRANT_x. No pop happens in the IDLE cycle, which gives a one-cycle bubble between packets.
  - Any source that is non-empty with sop=0 at its head (and is not granted this cycle) gets popped and discarded. err_frame pulses. Discards occur at most one word per source per cycle.
- GRANT_x:
  - srcX_rd_en = !srcX_empty && !out_stall.
  - A popped word is registered to outdata/outsop/outeop with outvalid=1 on the next cycle. Otherwise outvalid=0 on the next cycle.
  - Popping the eop word: next state IDLE, rr_last=x.
  - Source empty mid-packet: hold the grant and wait.
  - out_stall=1: no pop.
  - Other source: never popped.
- Latency: a 3-word packet on A with the arbiter IDLE at cycle 0 gives:
  - GRANT_A at cycles 1-3, pops at cycles 1-3;
  - outvalid at cycles 2-4, outsop at cycle 2, outeop at cycle 4;
  - IDLE again at cycle 4.
- Single-word packet (sop=eop=1): forwarded with both flags set. Returns to IDLE after one pop.
- Simultaneous: while GRANT_A, packets arriving on B wait. B is granted at the next IDLE cycle even if A has another packet queued.
- Reset mid-packet: outputs clear immediately. Any partial packet left in a FIFO is later discarded via err_frame.

Optional Feature:
ETH_ARB_WDOG_EN:
- Defined:
  - A word counter per granted packet is cleared on grant and incremented on each pop.
  - If the pop that reaches MAX_PKT_WORDS words is not eop, that word is forced to outeop=1, err_len pulses the same cycle, and the next state is FLUSH_x.
  - FLUSH_x pops srcX (when !empty, ignoring out_stall) with outvalid=0, until the eop word is popped. Next state is IDLE, rr_last=x.
- Undefined: no counter and no FLUSH states; err_len tied to 0; packets of any length pass.

Test Plan:
- Single A packet of 3 words (D0..D2, sop on D0, eop on D2), B empty -> outvalid cycles 2-4 with D0..D2, outsop at cycle 2, outeop at cycle 4; grant_a cycles 1-3; srcB_rd_en never asserted.
- A and B each hold a 2-word packet at cycle 0 -> A forwarded first (out cycles 2-3), IDLE at cycle 3, GRANT_B at cycle 4, B words out at cycles 5-6. With a second A packet queued, the next grant is back to A.
- out_stall=1 for cycles 2-3 during a 4-word A packet -> no pops in those cycles, outvalid=0 at cycles 3-4, word order preserved, no duplicates.
- srcA_empty=1 after the first word of a 3-word packet for 5 cycles -> grant_a held, B packet not served until A's eop is forwarded.
- A head word with sop=0 in IDLE -> popped, err_frame=1 for one cycle, nothing forwarded, state stays IDLE.
- ETH_ARB_WDOG_EN with MAX_PKT_WORDS=4 and a 6-word packet -> 4 words out with outeop on the 4th, err_len pulse; remaining 2 words flushed; IDLE afterwards. Without the macro, all 6 words are forwarded.

Source files
------------

// File: rtl/eth_out_arb.sv
// eth_out_arb: per-output-port packet arbiter for the 2x2 Ethernet switch.
// Shares one output port between two FWFT source FIFOs with packet-granular
// round-robin arbitration.
// Optional build macro: ETH_ARB_WDOG_EN enables a per-packet length watchdog
// that truncates packets at MAX_PKT_WORDS and flushes the remainder.
module eth_out_arb #(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MAX_PKT_WORDS = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              srcA_empty,
    input  logic [DATA_W-1:0] srcA_data,
    input  logic              srcA_sop,
    input  logic              srcA_eop,
    output logic              srcA_rd_en,
    input  logic              srcB_empty,
    input  logic [DATA_W-1:0] srcB_data,
    input  logic              srcB_sop,
    input  logic              srcB_eop,
    output logic              srcB_rd_en,
    input  logic              out_stall,
    output logic [DATA_W-1:0] outdata,
    output logic              outsop,
    output logic              outeop,
    output logic              outvalid,
    output logic              grant_a,
    output logic              grant_b,
    output logic              err_frame,
    output logic              err_len
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT_A = 3'd1,
        GRANT_B = 3'd2
`ifdef ETH_ARB_WDOG_EN
        ,
        FLUSH_A = 3'd3,
        FLUSH_B = 3'd4
`endif
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Reject a zero-length watchdog limit at elaboration.
    if (MAX_PKT_WORDS == 0) begin : g_bad_cfg
        $error("eth_out_arb: MAX_PKT_WORDS must be nonzero");
    end

    state_t              state, state_nxt;
    logic                rr_last, rr_nxt;
    logic                rd_a, rd_b;
    logic                cand_a, cand_b;
    logic [DATA_W-1:0]   outdata_nxt;
    logic                outsop_nxt, outeop_nxt, outvalid_nxt;
    logic                err_frame_nxt, err_len_nxt;

`ifdef ETH_ARB_WDOG_EN
    localparam int unsigned CNT_W = $clog2(MAX_PKT_WORDS + 1);
    logic [CNT_W-1:0] wcnt, wcnt_nxt, wcnt_inc;
    assign wcnt_inc = wcnt + CNT_W'(1);
`endif

    assign cand_a = !srcA_empty && srcA_sop;
    assign cand_b = !srcB_empty && srcB_sop;

    // Pops are suppressed while reset is held so no FIFO word is lost.
    assign srcA_rd_en = rd_a & rstn;
    assign srcB_rd_en = rd_b & rstn;

    // Next-state, pop and output-word decode.
    always_comb begin
        state_nxt     = state;
        rr_nxt        = rr_last;
        rd_a          = 1'b0;
        rd_b          = 1'b0;
        outvalid_nxt  = 1'b0;
        outdata_nxt   = outdata;
        outsop_nxt    = 1'b0;
        outeop_nxt    = 1'b0;
        err_frame_nxt = 1'b0;
        err_len_nxt   = 1'b0;
`ifdef ETH_ARB_WDOG_EN
        wcnt_nxt      = wcnt;
`endif
        case (state)
            IDLE: begin
                if (cand_a && (!cand_b || rr_last == SRC_B)) begin
                    state_nxt = GRANT_A;
                end else if (cand_b) begin
                    state_nxt = GRANT_B;
                end
`ifdef ETH_ARB_WDOG_EN
                wcnt_nxt = '0;
`endif
                // Orphan (non-sop) head words are dropped one per cycle.
                if (!srcA_empty && !srcA_sop) begin
                    rd_a          = 1'b1;
                    err_frame_nxt = 1'b1;
                end
                if (!srcB_empty && !srcB_sop) begin
                    rd_b          = 1'b1;
                    err_frame_nxt = 1'b1;
                end
            end
            GRANT_A: begin
                if (!srcA_empty && !out_stall) begin
                    rd_a         = 1'b1;
                    outvalid_nxt = 1'b1;
                    outdata_nxt  = srcA_data;
                    outsop_nxt   = srcA_sop;
                    outeop_nxt   = srcA_eop;
`ifdef ETH_ARB_WDOG_EN
                    wcnt_nxt     = wcnt_inc;
`endif
                    if (srcA_eop) begin
                        state_nxt = IDLE;
                        rr_nxt    = SRC_A;
                    end
`ifdef ETH_ARB_WDOG_EN
                    else if (wcnt_inc == CNT_W'(MAX_PKT_WORDS)) begin
                        outeop_nxt  = 1'b1;
                        err_len_nxt = 1'b1;
                        state_nxt   = FLUSH_A;
                    end
`endif
                end
            end
            GRANT_B: begin
                if (!srcB_empty && !out_stall) begin
                    rd_b         = 1'b1;
                    outvalid_nxt = 1'b1;
                    outdata_nxt  = srcB_data;
                    outsop_nxt   = srcB_sop;
                    outeop_nxt   = srcB_eop;
`ifdef ETH_ARB_WDOG_EN
                    wcnt_nxt     = wcnt_inc;
`endif
                    if (srcB_eop) begin
                        state_nxt = IDLE;
                        rr_nxt    = SRC_B;
                    end
`ifdef ETH_ARB_WDOG_EN
                    else if (wcnt_inc == CNT_W'(MAX_PKT_WORDS)) begin
                        outeop_nxt  = 1'b1;
                        err_len_nxt = 1'b1;
                        state_nxt   = FLUSH_B;
                    end
`endif
                end
            end
`ifdef ETH_ARB_WDOG_EN
            // Drain the truncated packet's tail without forwarding it.
            FLUSH_A: begin
                if (!srcA_empty) begin
                    rd_a = 1'b1;
                    if (srcA_eop) begin
                        state_nxt = IDLE;
                        rr_nxt    = SRC_A;
                    end
                end
            end
            FLUSH_B: begin
                if (!srcB_empty) begin
                    rd_b = 1'b1;
                    if (srcB_eop) begin
                        state_nxt = IDLE;
                        rr_nxt    = SRC_B;
                    end
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // State, round-robin pointer and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            rr_last   <= SRC_B;
            outdata   <= '0;
            outsop    <= 1'b0;
            outeop    <= 1'b0;
            outvalid  <= 1'b0;
            grant_a   <= 1'b0;
            grant_b   <= 1'b0;
            err_frame <= 1'b0;
            err_len   <= 1'b0;
`ifdef ETH_ARB_WDOG_EN
            wcnt      <= '0;
`endif
        end else begin
            state     <= state_nxt;
            rr_last   <= rr_nxt;
            outdata   <= outdata_nxt;
            outsop    <= outsop_nxt;
            outeop    <= outeop_nxt;
            outvalid  <= outvalid_nxt;
            grant_a   <= (state_nxt == GRANT_A);
            grant_b   <= (state_nxt == GRANT_B);
            err_frame <= err_frame_nxt;
            err_len   <= err_len_nxt;
`ifdef ETH_ARB_WDOG_EN
            wcnt      <= wcnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_eth_out_arb.sv
// Testbench for eth_out_arb: FWFT FIFO models plus an output scoreboard.
// Watchdog expectations follow ETH_ARB_WDOG_EN (MAX_PKT_WORDS = 4).
module tb_eth_out_arb;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MAX_W  = 4;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } word_t;

    logic              clk;
    logic              rstn;
    logic              srcA_empty, srcA_sop, srcA_eop, srcA_rd_en;
    logic [DATA_W-1:0] srcA_data;
    logic              srcB_empty, srcB_sop, srcB_eop, srcB_rd_en;
    logic [DATA_W-1:0] srcB_data;
    logic              out_stall;
    logic [DATA_W-1:0] outdata;
    logic              outsop, outeop, outvalid;
    logic              grant_a, grant_b, err_frame, err_len;

    word_t qa[$];
    word_t qb[$];
    word_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    logic  last_rd_a, last_rd_b;
    word_t hold1, hold2;

    eth_out_arb #(.DATA_W(DATA_W), .MAX_PKT_WORDS(MAX_W)) dut (
        .clk(clk), .rstn(rstn),
        .srcA_empty(srcA_empty), .srcA_data(srcA_data), .srcA_sop(srcA_sop),
        .srcA_eop(srcA_eop), .srcA_rd_en(srcA_rd_en),
        .srcB_empty(srcB_empty), .srcB_data(srcB_data), .srcB_sop(srcB_sop),
        .srcB_eop(srcB_eop), .srcB_rd_en(srcB_rd_en),
        .out_stall(out_stall),
        .outdata(outdata), .outsop(outsop), .outeop(outeop), .outvalid(outvalid),
        .grant_a(grant_a), .grant_b(grant_b),
        .err_frame(err_frame), .err_len(err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic in_rng(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // Present FIFO heads (first-word-fall-through).
    task automatic drive_heads();
        srcA_empty = (qa.size() == 0);
        srcB_empty = (qb.size() == 0);
        if (qa.size() != 0) begin
            srcA_data = qa[0].data; srcA_sop = qa[0].sop; srcA_eop = qa[0].eop;
        end else begin
            srcA_data = '0; srcA_sop = 1'b0; srcA_eop = 1'b0;
        end
        if (qb.size() != 0) begin
            srcB_data = qb[0].data; srcB_sop = qb[0].sop; srcB_eop = qb[0].eop;
        end else begin
            srcB_data = '0; srcB_sop = 1'b0; srcB_eop = 1'b0;
        end
    endtask

    task automatic load_pkt(input logic to_b, input int n, input logic [DATA_W-1:0] base,
                            input logic fwd);
        word_t w;
        for (int i = 0; i < n; i++) begin
            w.data = base + DATA_W'(i);
            w.sop  = (i == 0);
            w.eop  = (i == n - 1);
            if (to_b) qb.push_back(w); else qa.push_back(w);
            if (fwd) exp_q.push_back(w);
        end
    endtask

    // One clock: sample pops before the edge, apply them, score the output word.
    task automatic tick();
        word_t e;
        word_t tmp;
        drive_heads();
        #2;
        last_rd_a = srcA_rd_en;
        last_rd_b = srcB_rd_en;
        @(posedge clk);
        #1;
        if (last_rd_a) begin
            check("pop_a_nonempty", 64'(qa.size() != 0), 64'd1);
            if (qa.size() != 0) tmp = qa.pop_front();
        end
        if (last_rd_b) begin
            check("pop_b_nonempty", 64'(qb.size() != 0), 64'd1);
            if (qb.size() != 0) tmp = qb.pop_front();
        end
        if (outvalid) begin
            if (exp_q.size() == 0) begin
                check("sb_extra", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_word", 64'({outdata, outsop, outeop}), 64'(e));
            end
        end
    endtask

    task automatic do_reset(input logic clear);
        check("sb_left", 64'(exp_q.size()), 64'd0);
        rstn = 1'b0;
        #1;
        check("rst_valid", 64'(outvalid), 64'd0);
        check("rst_grant", 64'({grant_a, grant_b}), 64'd0);
        check("rst_flags", 64'({outsop, outeop, err_frame, err_len}), 64'd0);
        check("rst_data", 64'(outdata), 64'd0);
        check("rst_rd", 64'({srcA_rd_en, srcB_rd_en}), 64'd0);
        exp_q.delete();
        if (clear) begin
            qa.delete();
            qb.delete();
        end
        out_stall = 1'b0;
        drive_heads();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        word_t w;
        rstn = 1'b1;
        out_stall = 1'b0;
        drive_heads();
        #2;
        do_reset(1'b1);

        // Single 3-word packet on A.
        load_pkt(1'b0, 3, 32'hA000_0000, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            tick();
            check("t1_grant_a", 64'(grant_a), 64'(in_rng(c, 1, 3)));
            check("t1_valid", 64'(outvalid), 64'(in_rng(c, 2, 4)));
            check("t1_sop", 64'(outsop), 64'(c == 2));
            check("t1_eop", 64'(outeop), 64'(c == 4));
            check("t1_rd_b", 64'(last_rd_b), 64'd0);
        end

        // A and B contend; round-robin A, B, A.
        do_reset(1'b1);
        load_pkt(1'b0, 2, 32'hA100_0000, 1'b1);
        load_pkt(1'b1, 2, 32'hB200_0000, 1'b1);
        load_pkt(1'b0, 2, 32'hA300_0000, 1'b1);
        for (int c = 1; c <= 11; c++) begin
            tick();
            check("t2_grant_a", 64'(grant_a), 64'(in_rng(c, 1, 2) || in_rng(c, 7, 8)));
            check("t2_grant_b", 64'(grant_b), 64'(in_rng(c, 4, 5)));
            check("t2_valid", 64'(outvalid),
                  64'(in_rng(c, 2, 3) || in_rng(c, 5, 6) || in_rng(c, 8, 9)));
        end

        // Downstream stall during cycles 2-3 of a 4-word packet.
        do_reset(1'b1);
        load_pkt(1'b0, 4, 32'hC000_0000, 1'b1);
        for (int c = 1; c <= 9; c++) begin
            out_stall = in_rng(c - 1, 2, 3);
            tick();
            check("t3_rd_a", 64'(last_rd_a), 64'((c - 1 == 1) || in_rng(c - 1, 4, 6)));
            check("t3_grant_a", 64'(grant_a), 64'(in_rng(c, 1, 6)));
            check("t3_valid", 64'(outvalid), 64'((c == 2) || in_rng(c, 5, 7)));
        end
        out_stall = 1'b0;

        // A runs dry mid-packet; B waits for A's eop.
        do_reset(1'b1);
        load_pkt(1'b0, 3, 32'hD000_0000, 1'b1);
        hold2 = qa.pop_back();
        hold1 = qa.pop_back();
        load_pkt(1'b1, 2, 32'hE000_0000, 1'b1);
        for (int c = 1; c <= 13; c++) begin
            if (c == 8) begin
                qa.push_back(hold1);
                qa.push_back(hold2);
            end
            tick();
            check("t4_grant_a", 64'(grant_a), 64'(in_rng(c, 1, 8)));
            check("t4_grant_b", 64'(grant_b), 64'(in_rng(c, 10, 11)));
            check("t4_rd_b", 64'(last_rd_b), 64'(in_rng(c - 1, 10, 11)));
            check("t4_valid", 64'(outvalid),
                  64'((c == 2) || in_rng(c, 8, 9) || in_rng(c, 11, 12)));
        end

        // Orphan head word on A is discarded.
        do_reset(1'b1);
        w.data = 32'hDEAD_0001; w.sop = 1'b0; w.eop = 1'b1;
        qa.push_back(w);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("t5_rd_a", 64'(last_rd_a), 64'(c == 1));
            check("t5_err_frame", 64'(err_frame), 64'(c == 1));
            check("t5_grant", 64'({grant_a, grant_b}), 64'd0);
            check("t5_valid", 64'(outvalid), 64'd0);
        end

        // Single-word packet on B.
        load_pkt(1'b1, 1, 32'hF000_0000, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("t5s_grant_b", 64'(grant_b), 64'(c == 1));
            check("t5s_valid", 64'(outvalid), 64'(c == 2));
            check("t5s_flags", 64'({outsop, outeop}), (c == 2) ? 64'd3 : 64'd0);
        end

        // 6-word packet against a 4-word watchdog limit.
        do_reset(1'b1);
        load_pkt(1'b0, 6, 32'h6000_0000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            w.data = 32'h6000_0000 + DATA_W'(i);
            w.sop  = (i == 0);
`ifdef ETH_ARB_WDOG_EN
            w.eop  = (i == 3);
            if (i < 4) exp_q.push_back(w);
`else
            w.eop  = (i == 5);
            exp_q.push_back(w);
`endif
        end
        for (int c = 1; c <= 9; c++) begin
            tick();
`ifdef ETH_ARB_WDOG_EN
            check("t6_grant_a", 64'(grant_a), 64'(in_rng(c, 1, 4)));
            check("t6_valid", 64'(outvalid), 64'(in_rng(c, 2, 5)));
            check("t6_err_len", 64'(err_len), 64'(c == 5));
            check("t6_eop", 64'(outeop), 64'(c == 5));
`else
            check("t6_grant_a", 64'(grant_a), 64'(in_rng(c, 1, 6)));
            check("t6_valid", 64'(outvalid), 64'(in_rng(c, 2, 7)));
            check("t6_err_len", 64'(err_len), 64'd0);
            check("t6_eop", 64'(outeop), 64'(c == 7));
`endif
        end
        check("t6_drained", 64'(qa.size()), 64'd0);
        check("t6_idle", 64'({grant_a, grant_b}), 64'd0);

        // Reset mid-packet; the leftover tail is discarded afterwards.
        do_reset(1'b1);
        load_pkt(1'b0, 4, 32'h7000_0000, 1'b0);
        exp_q.push_back(qa[0]);
        tick();
        tick();
        do_reset(1'b0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("t7_err_frame", 64'(err_frame), 64'(in_rng(c, 1, 3)));
            check("t7_grant", 64'({grant_a, grant_b}), 64'd0);
            check("t7_valid", 64'(outvalid), 64'd0);
        end
        check("t7_drained", 64'(qa.size()), 64'd0);

        do_reset(1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
